// File: rtl/vfb_pkg.sv
// vfb_pkg: shared types and default sizing for the frame buffer read path.
// Request FSM encoding lives here so the bench and other units can see it.
package vfb_pkg;

   localparam int VFB_DEPTH     = 64;
   localparam int VFB_BURST_LEN = 16;
   localparam int VFB_ADDR_W    = 22;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } vfb_rd_state_t;

endpackage

// File: rtl/vfb_rd_prefetch_if.sv
// vfb_rd_prefetch_if: burst read channel between the prefetch stage
// and the memory controller.
interface vfb_rd_prefetch_if
   import vfb_pkg::*;
#(
   parameter int ADDR_W = VFB_ADDR_W
) ();

   logic              mem_rd_req_o;
   logic [ADDR_W-1:0] mem_rd_addr_o;
   logic              mem_rd_ack_i;
   logic              mem_rd_dv_i;
   logic [31:0]       mem_rd_d_i;

   modport master (
      output mem_rd_req_o,
      output mem_rd_addr_o,
      input  mem_rd_ack_i,
      input  mem_rd_dv_i,
      input  mem_rd_d_i
   );

   modport slave (
      input  mem_rd_req_o,
      input  mem_rd_addr_o,
      output mem_rd_ack_i,
      output mem_rd_dv_i,
      output mem_rd_d_i
   );

endinterface

// File: rtl/vfb_sfifo.sv
// vfb_sfifo: single-clock FIFO with a registered read port and level.
// Flush wins over push/pop; a pop on flush or on empty returns zero.
module vfb_sfifo #(
   parameter int DEPTH = 64,
   parameter int W     = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic [W-1:0]           wr_data,
   input  logic                   pop,
   output logic [W-1:0]           rd_data,
   output logic [$clog2(DEPTH):0] level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          pop_ok;

   assign pop_ok = pop && (level != '0);

   // storage needs no reset; the read register masks it until written
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         rd_data <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         if (pop) begin
            rd_data <= '0;
         end
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr];
         end else if (pop) begin
            rd_data <= '0;
         end
         level <= level + LW'(push) - LW'(pop_ok);
      end
   end

endmodule

// File: rtl/vfb_rd_prefetch.sv
// vfb_rd_prefetch: issues burst reads ahead of the unpacker and buffers
// the returned words; a frame restart flushes and discards stale beats.
module vfb_rd_prefetch
   import vfb_pkg::*;
#(
   parameter int DEPTH     = VFB_DEPTH,
   parameter int BURST_LEN = VFB_BURST_LEN,
   parameter int ADDR_W    = VFB_ADDR_W
) (
   input  logic                   sys_clk,
   input  logic                   rst_n,
   input  logic                   frame_rst_i,
   input  logic [ADDR_W-1:0]      frame_base_i,
   input  logic [ADDR_W-1:0]      frame_words_i,
   vfb_rd_prefetch_if.master      mem,
   input  logic                   dma_de_32b_i,
   output logic [31:0]            dma_d_32b_o,
   output logic [$clog2(DEPTH):0] fifo_level_o,
   output logic                   underflow_o
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int RW = LW + 1;

   localparam logic [LW-1:0]     BURST_L = LW'(BURST_LEN);
   localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_LEN);
   localparam logic [RW-1:0]     DEPTH_R = RW'(DEPTH);

   vfb_rd_state_t     state;
   vfb_rd_state_t     state_nxt;
   logic [ADDR_W-1:0] next_addr;
   logic [ADDR_W-1:0] next_addr_nxt;
   logic [ADDR_W-1:0] words_left;
   logic [ADDR_W-1:0] words_left_nxt;
   logic [ADDR_W-1:0] req_addr;
   logic [ADDR_W-1:0] req_addr_nxt;
   logic [LW-1:0]     outstanding;
   logic [LW-1:0]     outstanding_nxt;
   logic [LW-1:0]     discard_cnt;
   logic [LW-1:0]     discard_cnt_nxt;
   logic              stale;
   logic              stale_nxt;
   logic              ack_fresh;
   logic              ack_stale;
   logic              beat_drop;
   logic              beat_keep;
   logic              push;
   logic [RW-1:0]     resv;
   logic              can_issue;
   logic [LW-1:0]     level;

   assign beat_drop = mem.mem_rd_dv_i && (discard_cnt != '0);
   assign beat_keep = mem.mem_rd_dv_i && (discard_cnt == '0)
                      && (outstanding != '0);

   // space already promised to bursts in flight counts as occupied
   assign resv = RW'(level) + RW'(outstanding) + RW'(BURST_LEN);

   assign can_issue = (words_left != '0) && (discard_cnt == '0)
                      && (resv <= DEPTH_R) && !frame_rst_i;

   always_comb begin
      state_nxt    = state;
      req_addr_nxt = req_addr;
      stale_nxt    = stale;
      ack_fresh    = 1'b0;
      ack_stale    = 1'b0;
      unique case (state)
         IDLE: begin
            if (can_issue) begin
               state_nxt    = REQ;
               req_addr_nxt = next_addr;
            end
         end
         REQ: begin
            if (mem.mem_rd_ack_i) begin
               state_nxt = IDLE;
               stale_nxt = 1'b0;
               ack_stale = stale || frame_rst_i;
               ack_fresh = !(stale || frame_rst_i);
            end else if (frame_rst_i) begin
               stale_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      next_addr_nxt   = next_addr;
      words_left_nxt  = words_left;
      outstanding_nxt = outstanding;
      discard_cnt_nxt = discard_cnt;
      push            = 1'b0;
      if (frame_rst_i) begin
         // a beat landing on the restart edge is from the old frame
         next_addr_nxt   = frame_base_i;
         words_left_nxt  = frame_words_i;
         outstanding_nxt = '0;
         discard_cnt_nxt = discard_cnt + outstanding
                           - LW'(beat_drop || beat_keep);
      end else begin
         push            = beat_keep;
         discard_cnt_nxt = discard_cnt - LW'(beat_drop);
         outstanding_nxt = outstanding - LW'(beat_keep);
         if (ack_fresh) begin
            next_addr_nxt   = next_addr + BURST_A;
            words_left_nxt  = words_left - BURST_A;
            outstanding_nxt = outstanding_nxt + BURST_L;
         end
      end
      if (ack_stale) begin
         discard_cnt_nxt = discard_cnt_nxt + BURST_L;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         next_addr   <= '0;
         words_left  <= '0;
         req_addr    <= '0;
         outstanding <= '0;
         discard_cnt <= '0;
         stale       <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         next_addr   <= next_addr_nxt;
         words_left  <= words_left_nxt;
         req_addr    <= req_addr_nxt;
         outstanding <= outstanding_nxt;
         discard_cnt <= discard_cnt_nxt;
         stale       <= stale_nxt;
         if (frame_rst_i) begin
            underflow_o <= 1'b0;
         end else if (dma_de_32b_i && (level == '0)) begin
            underflow_o <= 1'b1;
         end
      end
   end

   assign mem.mem_rd_req_o  = (state == REQ);
   assign mem.mem_rd_addr_o = req_addr;
   assign fifo_level_o      = level;

   vfb_sfifo #(
      .DEPTH (DEPTH),
      .W     (32)
   ) u_fifo (
      .clk     (sys_clk),
      .rst_n   (rst_n),
      .flush   (frame_rst_i),
      .push    (push),
      .wr_data (mem.mem_rd_d_i),
      .pop     (dma_de_32b_i),
      .rd_data (dma_d_32b_o),
      .level   (level)
   );

endmodule

// File: tb/tb_vfb_rd_prefetch.sv
// tb_vfb_rd_prefetch: directed scenarios for the read prefetch stage
// with hand-computed addresses, levels and data.
module tb_vfb_rd_prefetch;

   localparam int AW = 22;
   localparam int LW = 7;

   logic          sys_clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          frame_rst_i = 1'b0;
   logic [AW-1:0] frame_base_i = '0;
   logic [AW-1:0] frame_words_i = '0;
   logic          dma_de_32b_i = 1'b0;
   logic [31:0]   dma_d_32b_o;
   logic [LW-1:0] fifo_level_o;
   logic          underflow_o;

   int n_chk = 0;
   int n_fail = 0;

   vfb_rd_prefetch_if #(.ADDR_W(AW)) mem_if ();

   vfb_rd_prefetch #(
      .DEPTH     (64),
      .BURST_LEN (16),
      .ADDR_W    (AW)
   ) dut (
      .sys_clk       (sys_clk),
      .rst_n         (rst_n),
      .frame_rst_i   (frame_rst_i),
      .frame_base_i  (frame_base_i),
      .frame_words_i (frame_words_i),
      .mem           (mem_if),
      .dma_de_32b_i  (dma_de_32b_i),
      .dma_d_32b_o   (dma_d_32b_o),
      .fifo_level_o  (fifo_level_o),
      .underflow_o   (underflow_o)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic start_frame(input logic [AW-1:0] base,
                              input logic [AW-1:0] words);
      frame_rst_i   = 1'b1;
      frame_base_i  = base;
      frame_words_i = words;
      tick(1);
      frame_rst_i = 1'b0;
   endtask

   task automatic wait_req(input int max_cyc, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (mem_if.mem_rd_req_o === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic ack_req();
      mem_if.mem_rd_ack_i = 1'b1;
      tick(1);
      mem_if.mem_rd_ack_i = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d);
      mem_if.mem_rd_dv_i = 1'b1;
      mem_if.mem_rd_d_i  = d;
      tick(1);
      mem_if.mem_rd_dv_i = 1'b0;
   endtask

   task automatic test_reset();
      bit saw;
      rst_n = 1'b0;
      tick(2);
      n_chk++;
      if (mem_if.mem_rd_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_req: got %b want 0", mem_if.mem_rd_req_o);
      end
      n_chk++;
      if (mem_if.mem_rd_addr_o !== 22'h0) begin
         n_fail++;
         $display("FAIL reset_addr: got %h want 0", mem_if.mem_rd_addr_o);
      end
      n_chk++;
      if (fifo_level_o !== 7'd0 || dma_d_32b_o !== 32'h0
          || underflow_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outs: level %0d data %h unf %b want 0 0 0",
                  fifo_level_o, dma_d_32b_o, underflow_o);
      end
      rst_n = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (mem_if.mem_rd_req_o !== 1'b0) saw = 1'b1;
      end
      n_chk++;
      if (saw !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_req: got req=%b want 0 before frame", saw);
      end
   endtask

   task automatic test_basic_fill();
      bit seen;
      bit saw;
      logic [AW-1:0] exp_a;
      start_frame(22'h100, 22'd64);
      for (int b = 0; b < 4; b++) begin
         exp_a = 22'(32'h100 + 16 * b);
         wait_req(20, seen);
         n_chk++;
         if (!seen || mem_if.mem_rd_addr_o !== exp_a) begin
            n_fail++;
            $display("FAIL fill_req[%0d]: got seen=%b addr %h want 1 %h",
                     b, seen, mem_if.mem_rd_addr_o, exp_a);
         end
         ack_req();
         for (int i = 0; i < 16; i++) begin
            send_beat(32'hF000_0000 + 32'(b * 16 + i));
         end
      end
      n_chk++;
      if (fifo_level_o !== 7'd64) begin
         n_fail++;
         $display("FAIL fill_level: got %0d want 64", fifo_level_o);
      end
      saw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (mem_if.mem_rd_req_o !== 1'b0) saw = 1'b1;
      end
      n_chk++;
      if (saw !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_no_fifth: got req=%b want 0", saw);
      end
   endtask

   task automatic test_streaming();
      bit seen;
      logic [31:0] expq[$];
      logic [31:0] exp_d;
      logic [AW-1:0] exp_a;
      start_frame(22'h200, 22'd32);
      for (int b = 0; b < 2; b++) begin
         exp_a = 22'(32'h200 + 16 * b);
         wait_req(20, seen);
         n_chk++;
         if (!seen || mem_if.mem_rd_addr_o !== exp_a) begin
            n_fail++;
            $display("FAIL stream_req[%0d]: got seen=%b addr %h want 1 %h",
                     b, seen, mem_if.mem_rd_addr_o, exp_a);
         end
         ack_req();
         for (int i = 0; i < 17; i++) begin
            mem_if.mem_rd_dv_i = (i < 16);
            mem_if.mem_rd_d_i  = 32'hA500_0000 + 32'(b * 16 + i);
            if (i < 16) expq.push_back(mem_if.mem_rd_d_i);
            dma_de_32b_i = (i > 0);
            tick(1);
            if (i > 0) begin
               exp_d = expq.pop_front();
               n_chk++;
               if (dma_d_32b_o !== exp_d) begin
                  n_fail++;
                  $display("FAIL stream_data[%0d.%0d]: got %h want %h",
                           b, i, dma_d_32b_o, exp_d);
               end
            end
         end
         mem_if.mem_rd_dv_i = 1'b0;
         dma_de_32b_i = 1'b0;
      end
      n_chk++;
      if (underflow_o !== 1'b0 || fifo_level_o !== 7'd0) begin
         n_fail++;
         $display("FAIL stream_end: unf %b level %0d want 0 0",
                  underflow_o, fifo_level_o);
      end
   endtask

   task automatic test_flush_mid_burst();
      bit seen;
      bit saw;
      bit lvl_bad;
      start_frame(22'h300, 22'd16);
      wait_req(20, seen);
      n_chk++;
      if (!seen || mem_if.mem_rd_addr_o !== 22'h300) begin
         n_fail++;
         $display("FAIL flush_req: got seen=%b addr %h want 1 300",
                  seen, mem_if.mem_rd_addr_o);
      end
      ack_req();
      for (int i = 0; i < 5; i++) send_beat(32'hB000_0000 + 32'(i));
      n_chk++;
      if (fifo_level_o !== 7'd5) begin
         n_fail++;
         $display("FAIL flush_pre_level: got %0d want 5", fifo_level_o);
      end
      start_frame(22'h800, 22'd16);
      n_chk++;
      if (fifo_level_o !== 7'd0) begin
         n_fail++;
         $display("FAIL flush_level: got %0d want 0", fifo_level_o);
      end
      saw = 1'b0;
      lvl_bad = 1'b0;
      for (int i = 0; i < 11; i++) begin
         send_beat(32'hB000_0005 + 32'(i));
         if (mem_if.mem_rd_req_o !== 1'b0) saw = 1'b1;
         if (fifo_level_o !== 7'd0) lvl_bad = 1'b1;
      end
      n_chk++;
      if (saw !== 1'b0 || lvl_bad !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_drop: got early_req=%b level_moved=%b want 0 0",
                  saw, lvl_bad);
      end
      tick(1);
      n_chk++;
      if (mem_if.mem_rd_req_o !== 1'b1 || mem_if.mem_rd_addr_o !== 22'h800) begin
         n_fail++;
         $display("FAIL flush_new_req: got req %b addr %h want 1 800",
                  mem_if.mem_rd_req_o, mem_if.mem_rd_addr_o);
      end
      ack_req();
      for (int i = 0; i < 16; i++) send_beat(32'hB800_0000 + 32'(i));
      n_chk++;
      if (fifo_level_o !== 7'd16) begin
         n_fail++;
         $display("FAIL flush_refill: got %0d want 16", fifo_level_o);
      end
   endtask

   task automatic test_stale_ack();
      bit seen;
      bit held;
      bit saw;
      bit lvl_bad;
      start_frame(22'h400, 22'd32);
      wait_req(20, seen);
      n_chk++;
      if (!seen || mem_if.mem_rd_addr_o !== 22'h400) begin
         n_fail++;
         $display("FAIL stale_req: got seen=%b addr %h want 1 400",
                  seen, mem_if.mem_rd_addr_o);
      end
      start_frame(22'hC00, 22'd16);
      held = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (mem_if.mem_rd_req_o !== 1'b1
             || mem_if.mem_rd_addr_o !== 22'h400) held = 1'b0;
         tick(1);
      end
      n_chk++;
      if (held !== 1'b1) begin
         n_fail++;
         $display("FAIL stale_hold: got held=%b want 1", held);
      end
      ack_req();
      n_chk++;
      if (mem_if.mem_rd_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL stale_idle: got req %b want 0", mem_if.mem_rd_req_o);
      end
      saw = 1'b0;
      lvl_bad = 1'b0;
      for (int i = 0; i < 16; i++) begin
         send_beat(32'hCC00_0000 + 32'(i));
         if (mem_if.mem_rd_req_o !== 1'b0) saw = 1'b1;
         if (fifo_level_o !== 7'd0) lvl_bad = 1'b1;
      end
      n_chk++;
      if (saw !== 1'b0 || lvl_bad !== 1'b0) begin
         n_fail++;
         $display("FAIL stale_drop: got early_req=%b level_moved=%b want 0 0",
                  saw, lvl_bad);
      end
      tick(1);
      n_chk++;
      if (mem_if.mem_rd_req_o !== 1'b1 || mem_if.mem_rd_addr_o !== 22'hC00) begin
         n_fail++;
         $display("FAIL stale_new_req: got req %b addr %h want 1 c00",
                  mem_if.mem_rd_req_o, mem_if.mem_rd_addr_o);
      end
      ack_req();
   endtask

   task automatic test_underflow();
      dma_de_32b_i = 1'b1;
      tick(1);
      dma_de_32b_i = 1'b0;
      n_chk++;
      if (dma_d_32b_o !== 32'h0 || underflow_o !== 1'b1
          || fifo_level_o !== 7'd0) begin
         n_fail++;
         $display("FAIL unf_pop: data %h unf %b level %0d want 0 1 0",
                  dma_d_32b_o, underflow_o, fifo_level_o);
      end
      tick(3);
      n_chk++;
      if (underflow_o !== 1'b1) begin
         n_fail++;
         $display("FAIL unf_sticky: got %b want 1", underflow_o);
      end
      start_frame(22'h500, 22'd32);
      n_chk++;
      if (underflow_o !== 1'b0) begin
         n_fail++;
         $display("FAIL unf_clear: got %b want 0", underflow_o);
      end
   endtask

   task automatic test_async_reset();
      bit seen;
      bit lvl_bad;
      lvl_bad = 1'b0;
      for (int i = 0; i < 16; i++) begin
         send_beat(32'hDEAD_0000 + 32'(i));
         if (fifo_level_o !== 7'd0) lvl_bad = 1'b1;
      end
      n_chk++;
      if (lvl_bad !== 1'b0) begin
         n_fail++;
         $display("FAIL ar_drain: got level_moved=%b want 0", lvl_bad);
      end
      wait_req(20, seen);
      n_chk++;
      if (!seen || mem_if.mem_rd_addr_o !== 22'h500) begin
         n_fail++;
         $display("FAIL ar_req0: got seen=%b addr %h want 1 500",
                  seen, mem_if.mem_rd_addr_o);
      end
      ack_req();
      for (int i = 0; i < 16; i++) send_beat(32'hC500_0000 + 32'(i));
      dma_de_32b_i = 1'b1;
      tick(1);
      dma_de_32b_i = 1'b0;
      n_chk++;
      if (dma_d_32b_o !== 32'hC500_0000 || fifo_level_o !== 7'd15) begin
         n_fail++;
         $display("FAIL ar_pop: data %h level %0d want c5000000 15",
                  dma_d_32b_o, fifo_level_o);
      end
      wait_req(20, seen);
      n_chk++;
      if (!seen || mem_if.mem_rd_addr_o !== 22'h510) begin
         n_fail++;
         $display("FAIL ar_req1: got seen=%b addr %h want 1 510",
                  seen, mem_if.mem_rd_addr_o);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (mem_if.mem_rd_req_o !== 1'b0 || mem_if.mem_rd_addr_o !== 22'h0) begin
         n_fail++;
         $display("FAIL ar_mem: req %b addr %h want 0 0",
                  mem_if.mem_rd_req_o, mem_if.mem_rd_addr_o);
      end
      n_chk++;
      if (fifo_level_o !== 7'd0 || dma_d_32b_o !== 32'h0
          || underflow_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ar_outs: level %0d data %h unf %b want 0 0 0",
                  fifo_level_o, dma_d_32b_o, underflow_o);
      end
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   initial begin
      mem_if.mem_rd_ack_i = 1'b0;
      mem_if.mem_rd_dv_i  = 1'b0;
      mem_if.mem_rd_d_i   = 32'h0;
      test_reset();
      test_basic_fill();
      test_streaming();
      test_flush_mid_burst();
      test_stale_ack();
      test_underflow();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
